// File: rtl/irq_collector_if.sv
// Bundle between event sources/interrupt handler and the irq_collector.
// The handler-side modport drives sources, mask writes and clear requests.
interface irq_collector_if #(
    parameter int N    = 8,
    parameter int ID_W = 3
);
    logic [N-1:0]    src;
    logic            mask_we;
    logic [N-1:0]    mask_in;
    logic            clr_valid;
    logic [N-1:0]    clr_bits;
    logic            clr_ready;
    logic [N-1:0]    pending;
    logic [N-1:0]    mask;
    logic            irq;
    logic [ID_W-1:0] irq_id;

    modport master (
        output src, mask_we, mask_in, clr_valid, clr_bits,
        input  clr_ready, pending, mask, irq, irq_id
    );

    modport slave (
        input  src, mask_we, mask_in, clr_valid, clr_bits,
        output clr_ready, pending, mask, irq, irq_id
    );
endinterface

// File: rtl/irq_collector.sv
// Sticky interrupt collector: captures source events, masks them, raises a
// registered irq with lowest-index id, and retires bits via a clear handshake.
module irq_collector #(
    parameter int N    = 8,
    parameter int ID_W = 3,
    parameter int EDGE = 1
) (
    input  logic           clk,
    input  logic           rst,
    irq_collector_if.slave bus
);
    typedef enum logic {IDLE = 1'b0, HOLD = 1'b1} state_t;

    state_t          state_reg, state_next;
    logic [N-1:0]    src_q_reg;
    logic [N-1:0]    pending_reg, pending_next;
    logic [N-1:0]    mask_reg;
    logic [N-1:0]    set_bits, clr_eff, active;
    logic            clr_ready_reg;
    logic            clr_accept;
    logic            irq_reg, irq_next;
    logic [ID_W-1:0] irq_id_reg, irq_id_next;

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_bit
            if (EDGE != 0) begin : g_edge
                assign set_bits[gi] = bus.src[gi] & ~src_q_reg[gi];
            end else begin : g_level
                assign set_bits[gi] = bus.src[gi];
            end
            assign clr_eff[gi]      = clr_accept & bus.clr_bits[gi];
            // OR-ing the set term last lets a same-cycle event survive its clear.
            assign pending_next[gi] = (pending_reg[gi] & ~clr_eff[gi]) | set_bits[gi];
            assign active[gi]       = pending_reg[gi] & mask_reg[gi];
        end
    endgenerate

    always_comb begin
        state_next = state_reg;
        clr_accept = 1'b0;
        case (state_reg)
            IDLE: begin
                if (bus.clr_valid) begin
                    clr_accept = 1'b1;
                    state_next = HOLD;
                end
            end
            HOLD: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        irq_next    = |active;
        irq_id_next = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (active[i]) begin
                irq_id_next = ID_W'(i);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            clr_ready_reg <= 1'b1;
            src_q_reg     <= '0;
            pending_reg   <= '0;
            mask_reg      <= '0;
            irq_reg       <= 1'b0;
            irq_id_reg    <= '0;
        end else begin
            state_reg     <= state_next;
            clr_ready_reg <= (state_next == IDLE);
            src_q_reg     <= bus.src;
            pending_reg   <= pending_next;
            if (bus.mask_we) begin
                mask_reg <= bus.mask_in;
            end
            irq_reg       <= irq_next;
            irq_id_reg    <= irq_id_next;
        end
    end

    assign bus.clr_ready = clr_ready_reg;
    assign bus.pending   = pending_reg;
    assign bus.mask      = mask_reg;
    assign bus.irq       = irq_reg;
    assign bus.irq_id    = irq_id_reg;
endmodule

// File: doc/irq_collector.md
Name: irq_collector

Overview:
- Receiving end of the OR-combined request path. N event sources each set a sticky pending bit.
- Pending bits are gated by a programmable enable mask and OR-reduced into a single registered interrupt line.
- The lowest pending source index is reported to the handler.
- The handler acknowledges through a valid/ready clear handshake, so this block is the responder that services and retires what an OR-gate aggregator raises.

Parameters:
- N, 8, number of event sources (1..32).
- ID_W, 3, width of irq_id; 2**ID_W >= N is required.
- EDGE, 1, 1 = capture on source rising edge; 0 = capture while source level is high.

Ports:
- clk  input  1  system clock, all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- src  input  N  raw event inputs, already synchronous to clk.
- mask_we  input  1  mask write strobe.
- mask_in  input  N  new mask value (1 = source enabled).
- clr_valid  input  1  clear request from handler.
- clr_bits  input  N  pending bits to clear (1 = clear).
- clr_ready  output  1  clear request can be accepted this cycle.
- pending  output  N  sticky pending status, unmasked.
- mask  output  N  current enable mask.
- irq  output  1  registered OR of (pending & mask).
- irq_id  output  ID_W  lowest index i with pending[i] & mask[i]; 0 when irq = 0.

Behaviour:
- Reset (rst = 1 at an edge) is checked first and overrides all else. Reset values:
  - src_q = 0, pending = 0, mask = 0.
  - irq = 0, irq_id = 0, state = IDLE, clr_ready = 1.
- Reset mid-handshake discards any in-flight clear and returns to IDLE.
- Capture:
  - src_q registers src every cycle.
  - EDGE = 1: set = src & ~src_q.
  - EDGE = 0: set = src.
  - A source held high through reset release produces one set in the first post-reset cycle (src_q = 0).
- Pending update: pending <= (pending & ~clr_eff) | set.
  - clr_eff = clr_bits when a clear is accepted this cycle, else 0.
  - Set wins over clear on the same bit in the same cycle; no event is lost.
- Mask: mask_we = 1 loads mask_in at that edge. Masking never alters pending; masked bits stay sticky.
- irq / irq_id:
  - Both are registered from the current registered pending & mask.
  - Latency: src low at edge k-1 and high at edge k gives pending bit = 1 after edge k, and irq = 1 after edge k+1.
  - A mask write at edge k affects irq after edge k+1.
  - irq_id uses fixed priority, lowest index first, and is updated in the same cycle as irq.
- Clear handshake FSM, two states:
  - IDLE: clr_ready = 1. If clr_valid = 1, the clear is accepted: clr_bits is applied at this edge and the FSM moves to HOLD.
  - HOLD: clr_ready = 0. clr_valid and clr_bits are ignored. The FSM returns to IDLE at the next edge.
  - clr_ready is registered: it is 0 for exactly the one cycle following acceptance.
  - This guarantees irq and irq_id reflect the clear before the handler can issue the next clear.
  - clr_bits = 0 is a legal no-op clear and still takes the HOLD cycle.
  - Clearing a bit that is not pending has no effect.
- Boundaries:
  - All N bits pending plus a full clear with no new sets gives pending = 0, and irq = 0 one cycle later.
  - mask = 0 with pending != 0 gives irq = 0 and irq_id = 0.
  - N not a power of two: irq_id never exceeds N-1.

Test Plan:
1. Reset then edge capture (N = 8, EDGE = 1, mask = 0xFF): src[3] 0→1 at edge k.
   - Required: pending = 0x08 after k; irq = 1 and irq_id = 3 after k+1.
   - Holding src[3] high sets nothing further.
2. Priority and mask: pending = 0x14 with mask = 0xFF.
   - Required: irq_id = 2.
   - Write mask = 0xF0: irq_id = 4 two edges after the write.
   - Write mask = 0x00: irq = 0, irq_id = 0, pending stays 0x14.
3. Clear handshake: pending = 0x14, clr_valid = 1, clr_bits = 0x04, held for 2 cycles.
   - Required: accepted once; clr_ready = 0 for one cycle; pending = 0x10; irq_id = 4 next cycle.
   - The second cycle's request is ignored.
4. Set/clear collision: src[1] rising edge in the same cycle a clear of 0x02 is accepted.
   - Required: pending[1] stays 1 and irq stays 1.
5. Reset mid-operation: pending = 0xFF, HOLD state, rst pulsed one cycle.
   - Required: pending = 0, mask = 0, irq = 0, irq_id = 0, clr_ready = 1 after that edge.
   - With src = 0x01 held high through reset, pending = 0x01 one cycle after release.
6. Level mode (EDGE = 0): src[0] held high, then clear 0x01 accepted.
   - Required: pending[0] remains 1 (set wins).
   - After src[0] drops and a further clear 0x01 is accepted: pending = 0, and irq = 0 one cycle later.
